// File: rtl/wshb_arbiter_if.sv
// Wishbone classic bus bundle between one master and one slave.
// Signals: cyc/stb/we/adr/dat_ms/sel travel master->slave; dat_sm/ack travel slave->master.
// Modports:
//   master - view of the side that issues cycles (drives cyc..sel, receives dat_sm/ack)
//   slave  - view of the side that answers cycles (receives cyc..sel, drives dat_sm/ack)
interface wshb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_ms;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_sm;
    logic            ack;

    modport master (output cyc, stb, we, adr, dat_ms, sel, input  dat_sm, ack);
    modport slave  (input  cyc, stb, we, adr, dat_ms, sel, output dat_sm, ack);
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with a per-grant burst limit.
// m0 (VGA reader) and m1 (frame writer) share one slave; ownership is re-decided
// at ack boundaries so a master that holds cyc continuously cannot starve the other.
// Ports:
//   wshb_clk  - sole clock
//   wshb_rst  - asynchronous active-high reset
//   m0, m1    - master-facing buses (slave modport: requests in, dat_sm/ack out)
//   s         - slave-facing bus (master modport: requests out, dat_sm/ack in)
//   grant     - one-hot owner status, bit0=m0, bit1=m1, 00 when nobody owns the bus
module wshb_arbiter #(
    parameter int unsigned MAX_BURST = 64,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32
) (
    input  logic       wshb_clk,
    input  logic       wshb_rst,
    wshb_if.slave      m0,
    wshb_if.slave      m1,
    wshb_if.master     s,
    output logic [1:0] grant
);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam int unsigned SW = DW / 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT0   = 2'd1,
        GNT1   = 2'd2,
        SWITCH = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;          // 1 = m1 held the bus last
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    // Owner-relative views so GNT0/GNT1 share one set of transition rules
    logic own_id_c;
    logic own_cyc_c;
    logic oth_cyc_c;

    assign own_id_c  = (state_q == GNT1);
    assign own_cyc_c = own_id_c ? m1.cyc : m0.cyc;
    assign oth_cyc_c = own_id_c ? m0.cyc : m1.cyc;

    // State register
    always_ff @(posedge wshb_clk or posedge wshb_rst) begin
        if (wshb_rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0.cyc) begin
                    state_d = GNT0;
                end else if (m1.cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_cyc_c) begin
                    state_d     = IDLE;
                    last_d      = own_id_c;
                    burst_cnt_d = '0;
                end else if (s.ack) begin
                    // >= also covers a saturated counter when the other master shows up late
                    if (oth_cyc_c && (burst_cnt_q >= CNT_LAST)) begin
                        state_d     = SWITCH;
                        last_d      = own_id_c;
                        burst_cnt_d = '0;
                    end else if (burst_cnt_q != CNT_SAT) begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                    end
                end
            end
            SWITCH: begin
                if (last_q) begin
                    state_d = m0.cyc ? GNT0 : IDLE;
                end else begin
                    state_d = m1.cyc ? GNT1 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus routing: owner's request to the slave, slave's ack only to the owner
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = AW'(0);
        s.dat_ms = DW'(0);
        s.sel    = SW'(0);
        m0.ack   = 1'b0;
        m1.ack   = 1'b0;
        grant    = 2'b00;
        unique case (state_q)
            GNT0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.cyc & m0.stb;
                s.we     = m0.we;
                s.adr    = m0.adr;
                s.dat_ms = m0.dat_ms;
                s.sel    = m0.sel;
                m0.ack   = s.ack & m0.cyc;
                grant    = 2'b01;
            end
            GNT1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.cyc & m1.stb;
                s.we     = m1.we;
                s.adr    = m1.adr;
                s.dat_ms = m1.dat_ms;
                s.sel    = m1.sel;
                m1.ack   = s.ack & m1.cyc;
                grant    = 2'b10;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; the ack alone tells a master the data is its own
    assign m0.dat_sm = s.dat_sm;
    assign m1.dat_sm = s.dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Scoreboard bench for wshb_arbiter (MAX_BURST=4): stimulus pushes expected acks,
// a monitor pops and compares every ack a master receives.
module tb_wshb_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 4;

    // Slave returns ~adr, so each master's read data is known up front
    localparam logic [DW-1:0] D_M0 = 32'hFFFF_EFFF;  // adr 0x1000
    localparam logic [DW-1:0] D_M1 = 32'hFFFF_DFFF;  // adr 0x2000
    localparam logic [DW-1:0] D_W1 = 32'hFFFF_FEFF;  // adr 0x0100

    logic       clk;
    logic       rst;
    logic [1:0] grant;

    wshb_if #(.AW(AW), .DW(DW)) m0_bus ();
    wshb_if #(.AW(AW), .DW(DW)) m1_bus ();
    wshb_if #(.AW(AW), .DW(DW)) s_bus ();

    wshb_arbiter #(.MAX_BURST(MB), .AW(AW), .DW(DW)) dut (
        .wshb_clk (clk),
        .wshb_rst (rst),
        .m0       (m0_bus),
        .m1       (m1_bus),
        .s        (s_bus),
        .grant    (grant)
    );

    typedef struct {
        logic          mid;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   failures;
    int   stall_n;
    logic force_ack;

    logic [1:0] s3_g [0:15] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                                2'b01, 2'b01, 2'b01, 2'b01, 2'b00};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign s_bus.dat_sm = ~s_bus.adr;

    // Slave: acks after stall_n wait cycles; force_ack drives a stray ack while s_cyc is low
    initial begin
        int wait_cnt;
        wait_cnt    = 0;
        s_bus.ack   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (s_bus.cyc && s_bus.stb) begin
                if (wait_cnt >= stall_n) begin
                    s_bus.ack = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    s_bus.ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                s_bus.ack = force_ack;
                wait_cnt  = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic run_monitor();
        exp_t          e;
        logic          got_mid;
        logic [DW-1:0] got_dat;
        forever begin
            @(negedge clk);
            if (m0_bus.ack && m1_bus.ack) begin
                checks++;
                failures++;
                $display("FAIL both_acks got=11 exp=one-hot");
            end else if (m0_bus.ack || m1_bus.ack) begin
                got_mid = m1_bus.ack;
                got_dat = got_mid ? m1_bus.dat_sm : m0_bus.dat_sm;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_ack got=m%0d/%0h exp=none", got_mid, got_dat);
                end else begin
                    e = sb_q.pop_front();
                    if (e.mid !== got_mid || e.dat !== got_dat) begin
                        failures++;
                        $display("FAIL sb_ack got=m%0d/%0h exp=m%0d/%0h", got_mid, got_dat, e.mid, e.dat);
                    end
                end
            end
        end
    endtask

    task automatic push(input logic mid, input int n, input logic [DW-1:0] d);
        repeat (n) sb_q.push_back('{mid: mid, dat: d});
    endtask

    task automatic drive(input int m, input logic cyc, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        if (m == 0) begin
            m0_bus.cyc = cyc; m0_bus.stb = cyc; m0_bus.we = we;
            m0_bus.adr = adr; m0_bus.dat_ms = dat; m0_bus.sel = '1;
        end else begin
            m1_bus.cyc = cyc; m1_bus.stb = cyc; m1_bus.we = we;
            m1_bus.adr = adr; m1_bus.dat_ms = dat; m1_bus.sel = '1;
        end
    endtask

    // Check one cycle at its negedge, then move to just after the next posedge
    task automatic step(input string name, input logic [1:0] eg, input logic esc);
        @(negedge clk);
        check({name, "_grant"}, 64'(grant), 64'(eg));
        check({name, "_scyc"}, 64'(s_bus.cyc), 64'(esc));
        if (eg == 2'b00) check({name, "_idle_adr"}, 64'(s_bus.adr), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        force_ack = 1'b0;
        stall_n   = 0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_scyc", 64'(s_bus.cyc), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        check({name, "_drain"}, 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        stall_n   = 0;
        force_ack = 1'b0;
        rst       = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        fork
            run_monitor();
        join_none

        // m0 alone, acked every cycle; then a stray ack with nobody on the bus
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h1000, '0);
        push(1'b0, 3, D_M0);
        step("s1", 2'b00, 1'b0);
        repeat (3) step("s1", 2'b01, 1'b1);
        drive(0, 1'b0, 1'b0, 32'h1000, '0);
        step("s1_drop", 2'b01, 1'b0);
        force_ack = 1'b1;
        step("s1_idle", 2'b00, 1'b0);
        @(negedge clk);
        check("s1_stray_m0_ack", 64'(m0_bus.ack), 64'(0));
        check("s1_stray_m1_ack", 64'(m1_bus.ack), 64'(0));
        check("s1_stray_grant", 64'(grant), 64'(0));
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        drain("s1");

        // Simultaneous request: m0 wins the first tie, m1 after m0 leaves
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h1000, '0);
        drive(1, 1'b1, 1'b0, 32'h2000, '0);
        push(1'b0, 2, D_M0);
        push(1'b1, 2, D_M1);
        step("s2", 2'b00, 1'b0);
        repeat (2) step("s2_m0", 2'b01, 1'b1);
        drive(0, 1'b0, 1'b0, 32'h1000, '0);
        step("s2_m0drop", 2'b01, 1'b0);
        step("s2_idle", 2'b00, 1'b0);
        repeat (2) step("s2_m1", 2'b10, 1'b1);
        drive(1, 1'b0, 1'b0, 32'h2000, '0);
        step("s2_m1drop", 2'b10, 1'b0);
        step("s2_end", 2'b00, 1'b0);
        drain("s2");

        // Both masters hold cyc: bursts of 4 separated by one dead cycle
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h1000, '0);
        drive(1, 1'b1, 1'b0, 32'h2000, '0);
        push(1'b0, 4, D_M0);
        push(1'b1, 4, D_M1);
        push(1'b0, 4, D_M0);
        for (int i = 0; i < 15; i++) step("s3", s3_g[i], s3_g[i] != 2'b00);
        drive(0, 1'b0, 1'b0, 32'h1000, '0);
        drive(1, 1'b0, 1'b0, 32'h2000, '0);
        step("s3_sw", s3_g[15], 1'b0);
        step("s3_end", 2'b00, 1'b0);
        drain("s3");

        // Saturated counter: late m1 request forces a switch on m0's next ack
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h1000, '0);
        push(1'b0, 11, D_M0);
        push(1'b1, 1, D_M1);
        step("s4", 2'b00, 1'b0);
        repeat (10) step("s4_m0", 2'b01, 1'b1);
        drive(1, 1'b1, 1'b0, 32'h2000, '0);
        step("s4_last", 2'b01, 1'b1);
        step("s4_sw", 2'b00, 1'b0);
        step("s4_m1", 2'b10, 1'b1);
        drive(0, 1'b0, 1'b0, 32'h1000, '0);
        drive(1, 1'b0, 1'b0, 32'h2000, '0);
        step("s4_drop", 2'b10, 1'b0);
        step("s4_end", 2'b00, 1'b0);
        drain("s4");

        // m1 write with a 3-cycle slave stall: request held stable, single ack
        do_reset();
        stall_n = 3;
        drive(1, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        push(1'b1, 1, D_W1);
        step("s5", 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("s5_grant", 64'(grant), 64'(2'b10));
            check("s5_adr", 64'(s_bus.adr), 64'(32'h0000_0100));
            check("s5_dat", 64'(s_bus.dat_ms), 64'(32'hDEAD_BEEF));
            check("s5_sel", 64'(s_bus.sel), 64'(4'hF));
            check("s5_we", 64'(s_bus.we), 64'(1));
            @(posedge clk);
            #1;
        end
        drive(1, 1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        step("s5_drop", 2'b10, 1'b0);
        step("s5_end", 2'b00, 1'b0);
        drain("s5");

        // Async reset in the middle of a GNT1 transfer
        do_reset();
        stall_n = 5;
        drive(1, 1'b1, 1'b0, 32'h2000, '0);
        step("s6", 2'b00, 1'b0);
        repeat (2) step("s6_m1", 2'b10, 1'b1);
        drive(0, 1'b1, 1'b0, 32'h1000, '0);
        rst = 1'b1;
        #1;
        check("s6_async_scyc", 64'(s_bus.cyc), 64'(0));
        check("s6_async_sstb", 64'(s_bus.stb), 64'(0));
        check("s6_async_grant", 64'(grant), 64'(0));
        check("s6_async_m1ack", 64'(m1_bus.ack), 64'(0));
        @(posedge clk);
        #1;
        rst     = 1'b0;
        stall_n = 0;
        push(1'b0, 1, D_M0);
        step("s6_rel", 2'b00, 1'b0);
        step("s6_m0", 2'b01, 1'b1);
        drive(0, 1'b0, 1'b0, 32'h1000, '0);
        drive(1, 1'b0, 1'b0, 32'h2000, '0);
        step("s6_drop", 2'b01, 1'b0);
        step("s6_end", 2'b00, 1'b0);
        drain("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
